// File: rtl/dca_matrix_lsu_txn_gen.sv
// Purpose: expands one matrix LSU instruction into one AXI address request plus one txn-info word per row.
// Latency: first ax_valid 2 cycles after instruction accept; each row costs 1 CALC + at least 1 ISSUE cycle.
// Backpressure: ax and txn channels stall independently; a row waits in ISSUE until both have handshaken once.
module dca_matrix_lsu_txn_gen #(
   parameter int BW_ADDR     = 32,
   parameter int BW_AXI_DATA = 32,
   parameter int MATRIX_SIZE = 4,
   parameter int BW_STRIDE   = 16,
   localparam int BW_BITADDR = $clog2(BW_AXI_DATA),
   localparam int BW_DIM     = $clog2(MATRIX_SIZE),
   localparam int BW_OFF     = BW_BITADDR - 3,
   localparam int BW_TXN     = BW_BITADDR + 10
) (
   input  logic                  clk,
   input  logic                  rstnn,
   input  logic                  clear,
   input  logic                  enable,
   input  logic                  inst_valid,
   output logic                  inst_ready,
   input  logic [BW_ADDR-1:0]    inst_addr,
   input  logic [BW_STRIDE-1:0]  inst_stride,
   input  logic [BW_DIM-1:0]     inst_nrow_m1,
   input  logic [BW_DIM-1:0]     inst_ncol_m1,
   output logic                  ax_valid,
   input  logic                  ax_ready,
   output logic [BW_ADDR-1:0]    ax_addr,
   output logic [7:0]            ax_len,
   output logic                  txn_valid,
   input  logic                  txn_ready,
   output logic [BW_TXN-1:0]     txn_info
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE} state_t;

   state_t                 state_q, state_d;
   logic [BW_ADDR-1:0]     row_addr_q;
   logic [BW_STRIDE-1:0]   stride_q;
   logic [BW_DIM-1:0]      nrow_q, ncol_q, row_q;
   logic [BW_ADDR-1:0]     ax_addr_q;
   logic [7:0]             ax_len_q;
   logic [BW_BITADDR-1:0]  bitaddr_q;
   logic                   is_first_q, is_last_q;
   logic                   ax_done_q, txn_done_q;

   logic [BW_OFF-1:0]      calc_off;
   logic [15:0]            calc_bytes;
   logic [7:0]             calc_len;
   logic                   ax_hs, txn_hs, row_done;

   // Per-row geometry: byte offset inside the first beat, and beats needed to cover the row
   always_comb begin
      calc_off   = row_addr_q[BW_OFF-1:0];
      calc_bytes = 16'(calc_off) + ((16'(ncol_q) + 16'd1) << 2);
      calc_len   = 8'((calc_bytes - 16'd1) >> BW_OFF);
   end

   assign ax_hs    = ax_valid & ax_ready;
   assign txn_hs   = txn_valid & txn_ready;
   assign row_done = (state_q == S_ISSUE) && enable &&
                     (ax_done_q | ax_hs) && (txn_done_q | txn_hs);

   // State register; clear beats any same-cycle transition
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn)
         state_q <= S_IDLE;
      else if (clear)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic; nothing moves while enable is low
   always_comb begin
      state_d = state_q;
      if (enable) begin
         case (state_q)
            S_IDLE:  if (inst_valid) state_d = S_CALC;
            S_CALC:  state_d = S_ISSUE;
            S_ISSUE: if (row_done) state_d = is_last_q ? S_IDLE : S_CALC;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output decode; valids are gated by enable so no handshake completes while held
   always_comb begin
      inst_ready = 1'b0;
      ax_valid   = 1'b0;
      txn_valid  = 1'b0;
      if (enable) begin
         inst_ready = (state_q == S_IDLE);
         ax_valid   = (state_q == S_ISSUE) && !ax_done_q;
         txn_valid  = (state_q == S_ISSUE) && !txn_done_q;
      end
   end

   // Datapath: latch instruction, register per-row values in CALC, track handshakes in ISSUE
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         row_addr_q <= '0;  stride_q  <= '0;  nrow_q     <= '0;  ncol_q    <= '0;
         row_q      <= '0;  ax_addr_q <= '0;  ax_len_q   <= '0;  bitaddr_q <= '0;
         is_first_q <= 1'b0; is_last_q <= 1'b0; ax_done_q <= 1'b0; txn_done_q <= 1'b0;
      end else if (clear) begin
         row_addr_q <= '0;  stride_q  <= '0;  nrow_q     <= '0;  ncol_q    <= '0;
         row_q      <= '0;  ax_addr_q <= '0;  ax_len_q   <= '0;  bitaddr_q <= '0;
         is_first_q <= 1'b0; is_last_q <= 1'b0; ax_done_q <= 1'b0; txn_done_q <= 1'b0;
      end else if (enable) begin
         case (state_q)
            S_IDLE: begin
               if (inst_valid) begin
                  row_addr_q <= inst_addr;
                  stride_q   <= inst_stride;
                  nrow_q     <= inst_nrow_m1;
                  ncol_q     <= inst_ncol_m1;
                  row_q      <= '0;
               end
            end
            S_CALC: begin
               ax_addr_q  <= {row_addr_q[BW_ADDR-1:BW_OFF], {BW_OFF{1'b0}}};
               ax_len_q   <= calc_len;
               bitaddr_q  <= {calc_off, 3'b000};
               is_first_q <= (row_q == '0);
               is_last_q  <= (row_q == nrow_q);
            end
            S_ISSUE: begin
               if (row_done) begin
                  ax_done_q  <= 1'b0;
                  txn_done_q <= 1'b0;
                  if (!is_last_q) begin
                     row_q      <= row_q + BW_DIM'(1);
                     row_addr_q <= row_addr_q + (BW_ADDR'(stride_q) << 3);
                  end
               end else begin
                  if (ax_hs)  ax_done_q  <= 1'b1;
                  if (txn_hs) txn_done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ax_addr  = ax_addr_q;
   assign ax_len   = ax_len_q;
   assign txn_info = {is_first_q, is_last_q, ax_len_q, bitaddr_q};

endmodule

// File: tb/tb_dca_matrix_lsu_txn_gen.sv
// Directed bench for dca_matrix_lsu_txn_gen: a 64-bit-data instance (8-byte beats) is the main target,
// a 32-bit-data instance shares its inputs to cover the 4-byte-beat geometry.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_dca_matrix_lsu_txn_gen;

   logic        clk = 1'b0;
   logic        rstnn, clear, enable, inst_valid;
   logic [31:0] inst_addr;
   logic [15:0] inst_stride;
   logic [1:0]  inst_nrow_m1, inst_ncol_m1;
   logic        ax_ready, txn_ready;

   logic        inst_ready, ax_valid, txn_valid;
   logic [31:0] ax_addr;
   logic [7:0]  ax_len;
   logic [15:0] txn_info;

   logic        inst_ready4, ax_valid4, txn_valid4;
   logic [31:0] ax_addr4;
   logic [7:0]  ax_len4;
   logic [14:0] txn_info4;

   int n_cmp = 0;
   int n_err = 0;
   int n_ax_hs;
   logic [15:0] want_info;

   always #5 clk = ~clk;

   dca_matrix_lsu_txn_gen #(.BW_ADDR(32), .BW_AXI_DATA(64), .MATRIX_SIZE(4), .BW_STRIDE(16)) u_dut (
      .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_addr(inst_addr),
      .inst_stride(inst_stride), .inst_nrow_m1(inst_nrow_m1), .inst_ncol_m1(inst_ncol_m1),
      .ax_valid(ax_valid), .ax_ready(ax_ready), .ax_addr(ax_addr), .ax_len(ax_len),
      .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_info(txn_info)
   );

   dca_matrix_lsu_txn_gen #(.BW_ADDR(32), .BW_AXI_DATA(32), .MATRIX_SIZE(4), .BW_STRIDE(16)) u_dut4 (
      .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable),
      .inst_valid(inst_valid), .inst_ready(inst_ready4), .inst_addr(inst_addr),
      .inst_stride(inst_stride), .inst_nrow_m1(inst_nrow_m1), .inst_ncol_m1(inst_ncol_m1),
      .ax_valid(ax_valid4), .ax_ready(ax_ready), .ax_addr(ax_addr4), .ax_len(ax_len4),
      .txn_valid(txn_valid4), .txn_ready(txn_ready), .txn_info(txn_info4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an instruction for one edge; afterwards the DUT is in CALC
   task automatic load(input logic [31:0] a, input logic [15:0] s, input logic [1:0] nr, input logic [1:0] nc);
      inst_addr    = a;
      inst_stride  = s;
      inst_nrow_m1 = nr;
      inst_ncol_m1 = nc;
      inst_valid   = 1'b1;
      tick();
      inst_valid   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstnn = 1'b0; clear = 1'b0; enable = 1'b1; inst_valid = 1'b0;
      inst_addr = '0; inst_stride = '0; inst_nrow_m1 = '0; inst_ncol_m1 = '0;
      ax_ready = 1'b1; txn_ready = 1'b1;
      #2;
      chk("rst_inst_ready", inst_ready, 1);
      chk("rst_ax_valid",   ax_valid,   0);
      chk("rst_txn_valid",  txn_valid,  0);
      chk("rst_ax_addr",    ax_addr,    0);
      chk("rst_ax_len",     ax_len,     0);
      chk("rst_txn_info",   txn_info,   0);
      #10 rstnn = 1'b1;
      tick();

      // 4x4 at 0x1000, stride 2 (16 bytes), 8-byte beats
      load(32'h1000, 16'd2, 2'd3, 2'd3);
      chk("t1_busy_inst_ready", inst_ready, 0);
      for (int r = 0; r < 4; r++) begin
         chk("t1_calc_ax_valid", ax_valid, 0);
         tick();
         want_info = {(r == 0), (r == 3), 8'd1, 6'd0};
         chk("t1_ax_valid",  ax_valid,  1);
         chk("t1_txn_valid", txn_valid, 1);
         chk("t1_ax_addr",   ax_addr,   32'h1000 + 32'(r) * 32'h10);
         chk("t1_ax_len",    ax_len,    1);
         chk("t1_txn_info",  txn_info,  want_info);
         tick();
      end
      chk("t1_idle_inst_ready", inst_ready, 1);

      // Unaligned single row, 4 cols at 0x1004: 8-byte and 4-byte beats
      load(32'h1004, 16'd0, 2'd0, 2'd3);
      tick();
      chk("t2_ax_addr_db8",  ax_addr,   32'h1000);
      chk("t2_ax_len_db8",   ax_len,    2);
      chk("t2_info_db8",     txn_info,  16'hC0A0);
      chk("t2_ax_addr_db4",  ax_addr4,  32'h1004);
      chk("t2_ax_len_db4",   ax_len4,   3);
      chk("t2_info_db4",     txn_info4, 15'h6060);
      tick();
      chk("t2_idle_db8", inst_ready,  1);
      chk("t2_idle_db4", inst_ready4, 1);

      // txn queue full for 5 cycles while ax is accepted
      txn_ready = 1'b0;
      load(32'h2000, 16'd1, 2'd1, 2'd1);
      tick();
      chk("t3_ax_valid",  ax_valid,  1);
      chk("t3_txn_valid", txn_valid, 1);
      n_ax_hs = int'(ax_valid & ax_ready);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_stall_txn_valid", txn_valid, 1);
         chk("t3_stall_txn_info",  txn_info,  16'h8000);
         chk("t3_stall_ax_valid",  ax_valid,  0);
         n_ax_hs += int'(ax_valid & ax_ready);
      end
      chk("t3_ax_hs_count", n_ax_hs, 1);
      txn_ready = 1'b1;
      tick();
      chk("t3_adv_txn_valid", txn_valid, 0);
      chk("t3_adv_ax_valid",  ax_valid,  0);
      tick();
      chk("t3_row1_ax_addr", ax_addr,  32'h2008);
      chk("t3_row1_info",    txn_info, 16'h4000);
      tick();

      // Single element at 0x20
      load(32'h20, 16'd0, 2'd0, 2'd0);
      tick();
      chk("t4_ax_addr", ax_addr,  32'h20);
      chk("t4_ax_len",  ax_len,   0);
      chk("t4_info",    txn_info, 16'hC000);
      tick();
      chk("t4_idle", inst_ready, 1);

      // Clear during row 2 of 4
      load(32'h1000, 16'd2, 2'd3, 2'd3);
      tick(); tick(); tick(); tick();
      tick();
      chk("t5_row2_ax_addr", ax_addr, 32'h1020);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t5_clr_ax_valid",   ax_valid,   0);
      chk("t5_clr_txn_valid",  txn_valid,  0);
      chk("t5_clr_inst_ready", inst_ready, 1);
      chk("t5_clr_ax_addr",    ax_addr,    0);

      // Clear wins over a same-cycle accept, then the instruction restarts at row 0
      inst_addr = 32'h3000; inst_stride = 16'd0; inst_nrow_m1 = 2'd1; inst_ncol_m1 = 2'd3;
      inst_valid = 1'b1;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t5_clear_beats_accept", inst_ready, 1);
      tick();
      inst_valid = 1'b0;
      chk("t5_accept", inst_ready, 0);
      tick();
      chk("t5_new_ax_addr", ax_addr,  32'h3000);
      chk("t5_new_info",    txn_info, 16'h8040);
      tick();
      tick();
      chk("t5_stride0_ax_addr", ax_addr,  32'h3000);
      chk("t5_stride0_info",    txn_info, 16'h4040);

      // enable low holds everything and masks valids
      enable = 1'b0;
      #1;
      chk("t6_dis_ax_valid",   ax_valid,   0);
      chk("t6_dis_txn_valid",  txn_valid,  0);
      chk("t6_dis_inst_ready", inst_ready, 0);
      tick(); tick();
      chk("t6_hold_ax_valid", ax_valid, 0);
      enable = 1'b1;
      #1;
      chk("t6_en_ax_valid", ax_valid, 1);
      chk("t6_en_ax_addr",  ax_addr,  32'h3000);
      tick();
      chk("t6_done_idle", inst_ready, 1);

      // Asynchronous reset while ax_valid is high
      load(32'h4000, 16'd1, 2'd1, 2'd3);
      tick();
      chk("t7_pre_ax_valid", ax_valid, 1);
      rstnn = 1'b0;
      #1;
      chk("t7_async_ax_valid",  ax_valid,  0);
      chk("t7_async_txn_valid", txn_valid, 0);
      #3 rstnn = 1'b1;
      tick();
      chk("t7_post_inst_ready", inst_ready, 1);
      chk("t7_post_ax_valid",   ax_valid,   0);
      chk("t7_post_ax_addr",    ax_addr,    0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
